aes_iter_core: RTL and testbench

- Iterative AES encryption core that processes one full block per transaction.
- Performs the initial AddRoundKey, then NR rounds at one round per clock, using a single aes_round instance. That instance has the interface state_in, round_key, is_last_round and state_out.
- Round keys are expanded on the fly, so no precomputed key table is needed.
- Sits between a block source and a block sink; both sides use valid/ready handshakes. It replaces manual round-by-round sequencing with a self-contained engine parametrised for AES-128 or AES-256.

---
 rtl/aes_iter_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_aes_iter_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// -----------------------------------------------------------------------------
// aes_iter_core: iterative AES encryption engine (AES-128 or AES-256).
//
// One block per transaction. The accept cycle applies the initial
// AddRoundKey. Each following cycle runs one round through a single
// aes_round instance, and the round keys are expanded on the fly. Both sides
// of the core use valid/ready handshakes.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   plaintext/key valid         in_ready   core can accept a block
//   in_data    plaintext, byte 0 at [127:120]
//   in_key     cipher key, byte 0 at the MSB
//   out_valid  ciphertext available        out_ready  sink accepts ciphertext
//   out_data   ciphertext                  busy       high while rounds run
//
// Also contains aes_pkg (GF(2^8) helpers, S-box, MixColumns) and aes_round.
// -----------------------------------------------------------------------------
package aes_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // The S-box is computed as the affine transform of the multiplicative
    // inverse. The inverse is x^254, built as x^2 * x^4 * ... * x^128, and
    // this also maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// One AES round: SubBytes, ShiftRows, MixColumns (skipped on the last round),
// then AddRoundKey. State byte (row r, column c) sits at index 4c+r.
module aes_round (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         is_last_round,
    output logic [127:0] state_out
);
    logic [127:0] sb_s;
    logic [127:0] sr_s;
    logic [127:0] mix_s;

    // SubBytes on all sixteen bytes
    always_comb begin
        sb_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sb_s[127-8*i -: 8] = aes_pkg::sbox(state_in[127-8*i -: 8]);
        end
    end

    // ShiftRows: row r rotates left by r columns
    always_comb begin
        sr_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    // MixColumns, one 32-bit column at a time
    always_comb begin
        mix_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            mix_s[127-32*c -: 32] = aes_pkg::mix_col(sr_s[127-32*c -: 32]);
        end
    end

    assign state_out = (is_last_round ? sr_s : mix_s) ^ round_key;
endmodule

module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);
    localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUND = 2'd1, ST_DONE = 2'd2} fsm_t;

    fsm_t                fsm_r;
    logic [127:0]        state_r;
    logic [KEY_BITS-1:0] key_r;
    logic [3:0]          round_r;
    logic [7:0]          rcon_r;

    logic [127:0]        rk_s;
    logic [KEY_BITS-1:0] key_next_s;
    logic [7:0]          rcon_next_s;
    logic [127:0]        round_out_s;

    if (KEY_BITS == 128) begin : g_ks128
        logic [31:0] t_s;
        logic [31:0] n0_s, n1_s, n2_s, n3_s;
        // AES-128 schedule: each round derives four fresh words from the window
        always_comb begin
            t_s  = aes_pkg::sub_word({key_r[23:0], key_r[31:24]}) ^ {rcon_r, 24'h000000};
            n0_s = key_r[127:96] ^ t_s;
            n1_s = n0_s ^ key_r[95:64];
            n2_s = n1_s ^ key_r[63:32];
            n3_s = n2_s ^ key_r[31:0];
            rk_s        = {n0_s, n1_s, n2_s, n3_s};
            key_next_s  = {n0_s, n1_s, n2_s, n3_s};
            rcon_next_s = aes_pkg::xtime(rcon_r);
        end
    end else if (KEY_BITS == 256) begin : g_ks256
        logic        even_s;
        logic [31:0] w7_s;
        logic [31:0] t_s;
        logic [31:0] n0_s, n1_s, n2_s, n3_s;
        // AES-256 schedule: round 1 uses the key's low half directly. Later
        // rounds alternate between RotWord+rcon (even) and SubWord only (odd).
        always_comb begin
            even_s = (round_r[0] == 1'b0);
            w7_s   = key_r[31:0];
            t_s    = aes_pkg::sub_word(even_s ? {w7_s[23:0], w7_s[31:24]} : w7_s)
                     ^ (even_s ? {rcon_r, 24'h000000} : 32'h00000000);
            n0_s   = key_r[255:224] ^ t_s;
            n1_s   = n0_s ^ key_r[223:192];
            n2_s   = n1_s ^ key_r[191:160];
            n3_s   = n2_s ^ key_r[159:128];
            if (round_r == 4'd1) begin
                rk_s        = key_r[127:0];
                key_next_s  = key_r;
                rcon_next_s = rcon_r;
            end else begin
                rk_s        = {n0_s, n1_s, n2_s, n3_s};
                key_next_s  = {key_r[127:0], n0_s, n1_s, n2_s, n3_s};
                rcon_next_s = even_s ? aes_pkg::xtime(rcon_r) : rcon_r;
            end
        end
    end else begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    aes_round u_round (
        .state_in      (state_r),
        .round_key     (rk_s),
        .is_last_round (round_r == NR),
        .state_out     (round_out_s)
    );

    // Control FSM: registered handshake outputs, state, key window and rcon
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r     <= ST_IDLE;
            state_r   <= 128'h0;
            key_r     <= '0;
            round_r   <= 4'd0;
            rcon_r    <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 128'h0;
            busy      <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_r  <= in_data ^ in_key[KEY_BITS-1 -: 128];
                        key_r    <= in_key;
                        round_r  <= 4'd1;
                        rcon_r   <= 8'h01;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm_r    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_r <= round_out_s;
                    key_r   <= key_next_s;
                    rcon_r  <= rcon_next_s;
                    round_r <= round_r + 4'd1;
                    if (round_r == NR) begin
                        out_data  <= round_out_s;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        fsm_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm_r     <= ST_IDLE;
                    end
                end
                default: begin
                    fsm_r     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// -----------------------------------------------------------------------------
// tb_aes_iter_core: scoreboard bench for aes_iter_core.
// dut_a is an AES-128 instance and dut_b an AES-256 instance; they share clk
// and rst. The drivers push the expected ciphertext and the accept time into a
// queue for each DUT. Independent monitors pop the queue when out_valid rises,
// compare data and latency, and check that out_data holds while it waits.
// -----------------------------------------------------------------------------
module tb_aes_iter_core;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] S_PT   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [255:0] S_KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] S_CT   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_in_key, a_out_data;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_out_data;
    logic [255:0] b_in_key;

    aes_iter_core #(.KEY_BITS(128)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_key(a_in_key), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );
    aes_iter_core #(.KEY_BITS(256)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_key(b_in_key), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    typedef struct {
        logic [127:0] data;
        time          t0;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor for dut_a: score the first cycle of out_valid, then check that the data holds
    initial begin
        exp_t         e;
        bit           seen = 1'b0;
        logic [127:0] hold = 128'h0;
        forever begin
            @(negedge clk);
            if (a_out_valid && !seen) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_output", 128'(a_out_valid), 128'd0);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", a_out_data, e.data);
                    check("a_latency", 128'(($time - 5 - e.t0) / 10), 128'd10);
                end
                seen = 1'b1;
                hold = a_out_data;
            end else if (a_out_valid) begin
                check("a_hold_stable", a_out_data, hold);
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Monitor for dut_b
    initial begin
        exp_t         e;
        bit           seen = 1'b0;
        logic [127:0] hold = 128'h0;
        forever begin
            @(negedge clk);
            if (b_out_valid && !seen) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_output", 128'(b_out_valid), 128'd0);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", b_out_data, e.data);
                    check("b_latency", 128'(($time - 5 - e.t0) / 10), 128'd14);
                end
                seen = 1'b1;
                hold = b_out_data;
            end else if (b_out_valid) begin
                check("b_hold_stable", b_out_data, hold);
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Called at a negedge. Returns at the negedge after the accept edge.
    task automatic send_a(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
        exp_t e;
        bit   done = 1'b0;
        a_in_data  = pt;
        a_in_key   = key;
        a_in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (a_in_ready) begin
                @(posedge clk);
                e.data = ct;
                e.t0   = $time;
                q_a.push_back(e);
                done = 1'b1;
                #1 a_in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("a_accept", 128'(done), 128'd1);
        a_in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_b(input logic [127:0] pt, input logic [255:0] key, input logic [127:0] ct);
        exp_t e;
        bit   done = 1'b0;
        b_in_data  = pt;
        b_in_key   = key;
        b_in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (b_in_ready) begin
                @(posedge clk);
                e.data = ct;
                e.t0   = $time;
                q_b.push_back(e);
                done = 1'b1;
                #1 b_in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("b_accept", 128'(done), 128'd1);
        b_in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Wait, with a bound, until every expected result has been scored
    task automatic drain();
        for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0 || a_out_valid || b_out_valid); i++) begin
            @(negedge clk);
        end
        check("drain_a", 128'(q_a.size()), 128'd0);
        check("drain_b", 128'(q_b.size()), 128'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0; a_in_data = 128'h0; a_in_key = 128'h0; a_out_ready = 1'b1;
        b_in_valid  = 1'b0; b_in_data = 128'h0; b_in_key = 256'h0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a_in_ready",  128'(a_in_ready),  128'd1);
        check("rst_a_out_valid", 128'(a_out_valid), 128'd0);
        check("rst_a_out_data",  a_out_data,        128'd0);
        check("rst_a_busy",      128'(a_busy),      128'd0);
        check("rst_b_in_ready",  128'(b_in_ready),  128'd1);
        check("rst_b_out_valid", 128'(b_out_valid), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1 and C.3
        send_a(C1_PT, C1_KEY, C1_CT);
        check("a_busy_round",     128'(a_busy),     128'd1);
        check("a_in_ready_round", 128'(a_in_ready), 128'd0);
        send_b(C1_PT, C3_KEY, C3_CT);
        check("b_busy_round", 128'(b_busy), 128'd1);
        drain();

        // Back-to-back blocks with different keys
        send_a(C1_PT, C1_KEY, C1_CT);
        send_a(B_PT, B_KEY, B_CT);
        send_b(C1_PT, C3_KEY, C3_CT);
        send_b(S_PT, S_KEY, S_CT);
        drain();

        // Inputs toggle during the rounds without effect
        send_a(C1_PT, C1_KEY, C1_CT);
        repeat (8) begin
            a_in_data = {$urandom, $urandom, $urandom, $urandom};
            a_in_key  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        drain();

        // Backpressure: hold the result 20 cycles while a new block is offered
        a_out_ready = 1'b0;
        send_a(C1_PT, C1_KEY, C1_CT);
        for (int i = 0; i < 40 && !a_out_valid; i++) @(negedge clk);
        check("a_bp_valid", 128'(a_out_valid), 128'd1);
        a_in_valid = 1'b1; a_in_data = B_PT; a_in_key = B_KEY;
        repeat (20) begin
            @(negedge clk);
            check("a_bp_in_ready", 128'(a_in_ready), 128'd0);
            check("a_bp_out_data", a_out_data, C1_CT);
        end
        a_out_ready = 1'b1;
        a_in_valid  = 1'b0;
        @(negedge clk);
        check("a_bp_release_valid", 128'(a_out_valid), 128'd0);
        check("a_bp_release_ready", 128'(a_in_ready),  128'd1);
        drain();

        // Reset while round 5 is in progress
        send_a(C1_PT, C1_KEY, C1_CT);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  128'(a_in_ready),  128'd1);
        check("mid_rst_out_valid", 128'(a_out_valid), 128'd0);
        check("mid_rst_out_data",  a_out_data,        128'd0);
        check("mid_rst_busy",      128'(a_busy),      128'd0);
        check("mid_rst_b_data",    b_out_data,        128'd0);
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_a(C1_PT, C1_KEY, C1_CT);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
